// File: rtl/control_pipe_unit.sv
// control_pipe_unit: RV32I decode into a registered Execute control slot.
// Define M_EXT_EN to add RV32M decode and the multi-cycle busy counter that holds Execute.
module control_pipe_unit #(
  parameter int ALU_CTRL_W = 5,
  parameter int MUL_LAT    = 3,
  parameter int DIV_LAT    = 33
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instrD,
  input  logic                  validD,
  input  logic                  stallD,
  input  logic                  flushE,
  output logic [2:0]            ImmSrcD,
  output logic                  RegWriteE,
  output logic                  ALUsrcE,
  output logic                  BranchE,
  output logic                  JumpE,
  output logic [1:0]            ResultSrcE,
  output logic [2:0]            R_sizeE,
  output logic [2:0]            DMem_sizeE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic                  validE,
  output logic                  illegalE,
  output logic                  mdBusy
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;
  localparam int EXW = ALU_CTRL_W + 14;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic legal, rw, src, br, jmp, capture;
  logic [1:0] rsel;
  logic [2:0] rsz, dsz;
  logic [ALU_CTRL_W-1:0] alu;
  logic [EXW-1:0] ex_d, ex_q;
  logic unused_fields;
`ifdef M_EXT_EN
  logic mop;
`endif

  assign opcode = instrD[6:0];
  assign funct3 = instrD[14:12];
  assign funct7 = instrD[31:25];
  // register specifiers are consumed by the datapath, not by control
  assign unused_fields = ^{instrD[24:15], instrD[11:7]};

  // base integer funct3 -> ALU code; alt selects SUB or SRA
  function automatic logic [3:0] base_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? 4'd1 : 4'd0;
      3'b001:  return 4'd5;
      3'b010:  return 4'd8;
      3'b011:  return 4'd9;
      3'b100:  return 4'd4;
      3'b101:  return alt ? 4'd7 : 4'd6;
      3'b110:  return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  // Decode raw control fields and legality; illegal words are collapsed to a marker-only slot
  always_comb begin
    legal = 1'b0; rw = 1'b0; src = 1'b0; br = 1'b0; jmp = 1'b0;
    rsel = 2'b00; rsz = 3'b000; dsz = 3'b000; alu = '0;
`ifdef M_EXT_EN
    mop = 1'b0;
`endif
    case (opcode)
      OP_R: begin
        rw = 1'b1;
        legal = funct7 == 7'b0000000 || (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
        alu = ALU_CTRL_W'(base_alu(funct3, funct7[5]));
`ifdef M_EXT_EN
        if (funct7 == 7'b0000001) begin
          legal = 1'b1; mop = 1'b1; alu = ALU_CTRL_W'({2'b10, funct3});
        end
`endif
      end
      OP_I: begin
        rw = 1'b1; src = 1'b1;
        legal = funct3 == 3'b001 ? funct7 == 7'b0000000 :
                funct3 == 3'b101 ? (funct7 == 7'b0000000 || funct7 == 7'b0100000) : 1'b1;
        alu = ALU_CTRL_W'(base_alu(funct3, funct3 == 3'b101 && funct7[5]));
      end
      OP_LD: begin
        rw = 1'b1; src = 1'b1; rsel = 2'b01; rsz = funct3;
        legal = funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111;
      end
      OP_ST: begin
        src = 1'b1; dsz = funct3; legal = funct3 < 3'b011;
      end
      OP_BR: begin
        br = 1'b1; alu = ALU_CTRL_W'(4'd1); legal = funct3 != 3'b010 && funct3 != 3'b011;
      end
      OP_JAL: begin
        rw = 1'b1; jmp = 1'b1; rsel = 2'b10; legal = 1'b1;
      end
      OP_JALR: begin
        rw = 1'b1; jmp = 1'b1; src = 1'b1; rsel = 2'b10; legal = funct3 == 3'b000;
      end
      OP_LUI: begin
        rw = 1'b1; src = 1'b1; alu = ALU_CTRL_W'(4'd10); legal = 1'b1;
      end
      OP_AUIPC: begin
        rw = 1'b1; src = 1'b1; legal = 1'b1;
      end
      default: ;
    endcase
  end

  // immediate format depends on the opcode alone so Decode sees it in the same cycle
  assign ImmSrcD = opcode == OP_ST ? 3'b001 : opcode == OP_BR ? 3'b010 : opcode == OP_JAL ? 3'b011 :
                   (opcode == OP_LUI || opcode == OP_AUIPC) ? 3'b100 : 3'b000;

  assign ex_d = legal ? {rw, src, br, jmp, rsel, rsz, dsz, alu, 2'b10} : {{(EXW-2){1'b0}}, 2'b11};
  assign capture = validD && !stallD;

  // Execute slot: flush kills, busy holds, otherwise capture a decoded word or insert a bubble
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ex_q <= '0;
    else if (flushE || (!mdBusy && !capture)) ex_q <= '0;
    else if (!mdBusy) ex_q <= ex_d;

  assign {RegWriteE, ALUsrcE, BranchE, JumpE, ResultSrcE, R_sizeE, DMem_sizeE, ALUControlE, validE, illegalE} = ex_q;

`ifdef M_EXT_EN
  localparam int MAX_LAT = MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT;
  localparam int CW = $clog2(MAX_LAT + 1);
  localparam logic [0:0] IDLE = 1'b0, BUSY = 1'b1;
  logic [CW-1:0] count, load;
  logic [0:0] state;
  assign load = funct3[2] ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
  // Busy counter: loaded when an M-op is captured, counts down while Execute holds, cleared by flush
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0; state <= IDLE;
    end else if (flushE) begin
      count <= '0; state <= IDLE;
    end else if (state == BUSY) begin
      count <= count - CW'(1); state <= count == CW'(1) ? IDLE : BUSY;
    end else if (capture && legal && mop) begin
      count <= load; state <= load != '0 ? BUSY : IDLE;
    end
  assign mdBusy = count != '0;
`else
  assign mdBusy = 1'b0;
`endif
endmodule

// File: tb/tb_control_pipe_unit.sv
// tb_control_pipe_unit: directed and randomized checks of control_pipe_unit against a behavioural model
module tb_control_pipe_unit;
  localparam int W = 5, MUL_LAT = 3, DIV_LAT = 4;
  localparam bit M_ON =
`ifdef M_EXT_EN
    1'b1;
`else
    1'b0;
`endif
  localparam logic [31:0] ADD = 32'h003100B3, LW = 32'h0000A083, DIV = 32'h023140B3, MUL = 32'h023100B3;
  localparam int ALU_OF_F3 [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
  localparam logic [6:0] OPS [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] instrD = '0;
  logic validD = 1'b0, stallD = 1'b0, flushE = 1'b0;
  logic [2:0] ImmSrcD, R_sizeE, DMem_sizeE;
  logic RegWriteE, ALUsrcE, BranchE, JumpE, validE, illegalE, mdBusy;
  logic [1:0] ResultSrcE;
  logic [W-1:0] ALUControlE;
  logic [19:0] obs;
  logic [18:0] m_ex = '0;
  int m_left = 0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  control_pipe_unit #(.ALU_CTRL_W(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .instrD(instrD), .validD(validD), .stallD(stallD), .flushE(flushE),
    .ImmSrcD(ImmSrcD), .RegWriteE(RegWriteE), .ALUsrcE(ALUsrcE), .BranchE(BranchE), .JumpE(JumpE),
    .ResultSrcE(ResultSrcE), .R_sizeE(R_sizeE), .DMem_sizeE(DMem_sizeE), .ALUControlE(ALUControlE),
    .validE(validE), .illegalE(illegalE), .mdBusy(mdBusy)
  );

  assign obs = {RegWriteE, ALUsrcE, BranchE, JumpE, ResultSrcE, R_sizeE, DMem_sizeE, ALUControlE, validE, illegalE, mdBusy};

  // expected Execute slot for an instruction, straight from the opcode/funct tables
  function automatic logic [18:0] ref_decode(input logic [31:0] i);
    logic [6:0] op, f7;
    logic [2:0] f3, rsz, dsz;
    logic [1:0] rs;
    bit ok, rw, src, br, jmp;
    int alu;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    ok = 0; rw = 0; src = 0; br = 0; jmp = 0; rs = 0; rsz = 0; dsz = 0; alu = 0;
    case (op)
      7'h33: begin
        rw = 1; alu = ALU_OF_F3[f3];
        if (f7 == 7'h00) ok = 1;
        else if (f7 == 7'h20 && f3 == 0) begin ok = 1; alu = 1; end
        else if (f7 == 7'h20 && f3 == 5) begin ok = 1; alu = 7; end
        else if (M_ON && f7 == 7'h01) begin ok = 1; alu = 16 + int'(f3); end
      end
      7'h13: begin
        rw = 1; src = 1; alu = ALU_OF_F3[f3];
        if (f3 == 1) ok = (f7 == 0);
        else if (f3 == 5) begin ok = (f7 == 0 || f7 == 7'h20); if (f7 == 7'h20) alu = 7; end
        else ok = 1;
      end
      7'h03: begin rw = 1; src = 1; rs = 1; rsz = f3; ok = f3 inside {0, 1, 2, 4, 5}; end
      7'h23: begin src = 1; dsz = f3; ok = f3 inside {0, 1, 2}; end
      7'h63: begin br = 1; alu = 1; ok = !(f3 inside {2, 3}); end
      7'h6F: begin rw = 1; jmp = 1; rs = 2; ok = 1; end
      7'h67: begin rw = 1; jmp = 1; src = 1; rs = 2; ok = (f3 == 0); end
      7'h37: begin rw = 1; src = 1; alu = 10; ok = 1; end
      7'h17: begin rw = 1; src = 1; ok = 1; end
      default: ok = 0;
    endcase
    return ok ? {rw, src, br, jmp, rs, rsz, dsz, 5'(alu), 2'b10} : 19'b11;
  endfunction

  function automatic logic [2:0] ref_imm(input logic [31:0] i);
    case (i[6:0])
      7'h23: return 3'd1;
      7'h63: return 3'd2;
      7'h6F: return 3'd3;
      7'h37, 7'h17: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  // extra cycles an instruction keeps Execute occupied after capture
  function automatic int ref_busy(input logic [31:0] i);
    if (M_ON && i[6:0] == 7'h33 && i[31:25] == 7'h01) return (i[14] ? DIV_LAT : MUL_LAT) - 1;
    return 0;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    i = $urandom;
    if ($urandom_range(7) != 0) i[6:0] = OPS[$urandom_range(9)];
    case ($urandom_range(3))
      0: i[31:25] = 7'h00;
      1: i[31:25] = 7'h20;
      2: i[31:25] = 7'h01;
      default: ;
    endcase
    return i;
  endfunction

  task automatic drive(input logic [31:0] i, input logic v, input logic s, input logic f);
    instrD = i; validD = v; stallD = s; flushE = f;
  endtask

  // one clock: advance the model with the inputs present at the edge, return at the falling edge
  task automatic tick();
    @(posedge clk);
    if (flushE) begin m_ex = '0; m_left = 0; end
    else if (m_left > 0) m_left--;
    else if (validD && !stallD) begin m_ex = ref_decode(instrD); m_left = ref_busy(instrD); end
    else m_ex = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(ADD, 1, 0, 0);
    repeat (2) @(negedge clk);
    n_chk++;
    if (obs !== 20'd0) begin $display("FAIL reset_state got=%h want=0", obs); n_fail++; end
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    m_ex = '0; m_left = 0;
    tick();
  endtask

  task automatic test_add();
    drive(ADD, 1, 0, 0);
    tick();
    n_chk++;
    if (obs !== {1'b1, 3'b000, 2'b00, 3'd0, 3'd0, 5'd0, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL add_fields got=%h want=%h", obs, {1'b1, 3'b000, 2'b00, 3'd0, 3'd0, 5'd0, 1'b1, 1'b0, 1'b0}); n_fail++;
    end
    n_chk++;
    if (obs !== {m_ex, m_left > 0}) begin $display("FAIL add_model got=%h want=%h", obs, {m_ex, m_left > 0}); n_fail++; end
  endtask

  task automatic test_load_imm();
    logic [31:0] ins [5] = '{32'h0020A023, 32'h00000063, 32'h0000006F, 32'h000000B7, 32'h00000097};
    logic [2:0] want [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    drive(LW, 1, 0, 0);
    #1;
    n_chk++;
    if (ImmSrcD !== 3'd0) begin $display("FAIL lw_imm got=%0d want=0", ImmSrcD); n_fail++; end
    tick();
    n_chk++;
    if ({ResultSrcE, R_sizeE, ALUsrcE, RegWriteE, validE} !== {2'b01, 3'b010, 3'b111}) begin
      $display("FAIL lw_fields got=%b want=%b", {ResultSrcE, R_sizeE, ALUsrcE, RegWriteE, validE}, {2'b01, 3'b010, 3'b111}); n_fail++;
    end
    for (int k = 0; k < 5; k++) begin
      drive(ins[k], 0, 0, 0);
      #1;
      n_chk++;
      if (ImmSrcD !== want[k]) begin $display("FAIL imm_sel%0d got=%0d want=%0d", k, ImmSrcD, want[k]); n_fail++; end
      tick();
    end
  endtask

  task automatic test_illegal();
    drive(32'hFFFFFFFF, 1, 0, 0);
    tick();
    n_chk++;
    if ({illegalE, validE, RegWriteE, BranchE, JumpE, DMem_sizeE} !== 8'b11000000) begin
      $display("FAIL illegal_ones got=%b want=11000000", {illegalE, validE, RegWriteE, BranchE, JumpE, DMem_sizeE}); n_fail++;
    end
    drive(MUL, 1, 0, 0);
    tick();
`ifdef M_EXT_EN
    n_chk++;
    if ({illegalE, ALUControlE, mdBusy} !== {1'b0, 5'd16, 1'b1}) begin
      $display("FAIL mul_decode got=%b want=%b", {illegalE, ALUControlE, mdBusy}, {1'b0, 5'd16, 1'b1}); n_fail++;
    end
`else
    n_chk++;
    if ({illegalE, RegWriteE, mdBusy} !== 3'b100) begin
      $display("FAIL mul_illegal got=%b want=100", {illegalE, RegWriteE, mdBusy}); n_fail++;
    end
`endif
    drive(0, 0, 0, 0);
    repeat (MUL_LAT) tick();
  endtask

  task automatic test_stall_flush();
    drive(ADD, 1, 0, 0);
    tick();
    drive(ADD, 1, 1, 0);
    tick();
    n_chk++;
    if (obs !== 20'd0) begin $display("FAIL stall_bubble got=%h want=0", obs); n_fail++; end
    drive(LW, 1, 0, 0);
    tick();
    drive(ADD, 1, 0, 1);
    tick();
    n_chk++;
    if (obs !== 20'd0) begin $display("FAIL flush_bubble got=%h want=0", obs); n_fail++; end
  endtask

  task automatic count_busy(input string name);
    int busy = 0;
    for (int k = 0; k < 12 && mdBusy === 1'b1; k++) begin
      busy++;
      stallD = k[0];
      n_chk++;
      if (ALUControlE !== 5'd20 || validE !== 1'b1) begin
        $display("FAIL %s_hold got=%0d/%b want=20/1", name, ALUControlE, validE); n_fail++;
      end
      tick();
    end
    n_chk++;
    if (busy !== DIV_LAT - 1) begin $display("FAIL %s_busy_cycles got=%0d want=%0d", name, busy, DIV_LAT - 1); n_fail++; end
  endtask

  task automatic test_div_busy();
    drive(DIV, 1, 0, 0);
    tick();
    drive(ADD, 1, 0, 0);
    count_busy("div");
    n_chk++;
    if (ALUControlE !== 5'd20 || mdBusy !== 1'b0) begin
      $display("FAIL div_last got=%0d/%b want=20/0", ALUControlE, mdBusy); n_fail++;
    end
    stallD = 1'b0;
    tick();
    n_chk++;
    if ({validE, RegWriteE, ALUControlE} !== {2'b11, 5'd0}) begin
      $display("FAIL div_next_add got=%b want=1100000", {validE, RegWriteE, ALUControlE}); n_fail++;
    end
  endtask

  task automatic test_flush_busy();
    drive(DIV, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    tick();
    flushE = 1'b1;
    tick();
    flushE = 1'b0;
    n_chk++;
    if ({mdBusy, validE} !== 2'b00) begin $display("FAIL flush_busy got=%b want=00", {mdBusy, validE}); n_fail++; end
  endtask

  task automatic test_reset_async();
    drive(M_ON ? DIV : ADD, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    n_chk++;
    if (validE !== 1'b1) begin $display("FAIL pre_reset_valid got=%b want=1", validE); n_fail++; end
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (obs !== 20'd0) begin $display("FAIL async_reset got=%h want=0", obs); n_fail++; end
    m_ex = '0; m_left = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef M_EXT_EN
    drive(DIV, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0);
    count_busy("post_reset");
    stallD = 1'b0;
    tick();
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      drive(rand_instr(), $urandom_range(3) != 0, $urandom_range(3) == 0, $urandom_range(9) == 0);
      #1;
      n_chk++;
      if (ImmSrcD !== ref_imm(instrD)) begin
        $display("FAIL rand_imm%0d instr=%h got=%0d want=%0d", k, instrD, ImmSrcD, ref_imm(instrD)); n_fail++;
      end
      tick();
      n_chk++;
      if (obs !== {m_ex, m_left > 0}) begin
        $display("FAIL rand_cycle%0d got=%h want=%h", k, obs, {m_ex, m_left > 0}); n_fail++;
      end
    end
    drive(0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_imm();
    test_illegal();
    test_stall_flush();
`ifdef M_EXT_EN
    test_div_busy();
    test_flush_busy();
`endif
    test_reset_async();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
